// File: rtl/noc_pkg.sv
// ============================================================================
// Module   : noc_pkg
// Brief    : Shared flit widths, header field positions, injector states and
//            the header pack helper for NoC local ports.
// Revision : 1.0
// ============================================================================
`default_nettype none

package noc_pkg;

  localparam int FLIT_W  = 8;
  localparam int COORD_W = 2;
  localparam int TTL_W   = 4;
  localparam int SEQ_W   = 4;

  // Header byte: {x[7:6], y[5:4], low nibble[3:0]} for both F0 and F1
  localparam int HDR_X_LSB   = 6;
  localparam int HDR_Y_LSB   = 4;
  localparam int HDR_LOW_LSB = 0;
  localparam int HDR_LOW_W   = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    ID    = 3'd2,
    LEN   = 3'd3,
    PAY   = 3'd4,
    DRAIN = 3'd5
  } state_t;

  function automatic logic [FLIT_W-1:0] pack_hdr(
    input logic [COORD_W-1:0]   x,
    input logic [COORD_W-1:0]   y,
    input logic [HDR_LOW_W-1:0] low
  );
    logic [FLIT_W-1:0] f;
    f = '0;
    f[HDR_X_LSB   +: COORD_W]   = x;
    f[HDR_Y_LSB   +: COORD_W]   = y;
    f[HDR_LOW_LSB +: HDR_LOW_W] = low;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/noc_flit_reg_slice.sv
// ============================================================================
// Module   : noc_flit_reg_slice
// Brief    : One-entry valid/ready output register with a "last" tag bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module noc_flit_reg_slice
  import noc_pkg::*;
#(
  parameter int W = FLIT_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_last,
  output logic         load_ok
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_last;

  // Accept a new entry when empty or when the current one leaves this cycle
  assign load_ok = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (load && load_ok) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
      r_last  <= load_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

`default_nettype wire

// File: rtl/noc_packet_injector.sv
// ============================================================================
// Module   : noc_packet_injector
// Brief    : Local-port transmitter: serialises request + payload into
//            header, message-ID, length and payload flits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module noc_packet_injector
  import noc_pkg::*;
#(
  parameter int X        = 4,
  parameter int Y        = 4,
  parameter int NODE_X   = 0,
  parameter int NODE_Y   = 0,
  parameter int TTL_INIT = 6,
  parameter int MAX_LEN  = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [COORD_W-1:0]  req_dst_x,
  input  logic [COORD_W-1:0]  req_dst_y,
  input  logic [7:0]          req_len,
  input  logic                pl_valid,
  output logic                pl_ready,
  input  logic [FLIT_W-1:0]   pl_data,
  output logic                o_valid,
  output logic [FLIT_W-1:0]   o_data,
  input  logic                i_ready,
  output logic                busy,
  output logic                pkt_sent,
  output logic                err
);

  localparam logic [7:0]         C_MAX_LEN = 8'(MAX_LEN);
  localparam logic [COORD_W:0]   C_X       = (COORD_W+1)'(X);
  localparam logic [COORD_W:0]   C_Y       = (COORD_W+1)'(Y);
  localparam logic [COORD_W-1:0] C_NODE_X  = COORD_W'(NODE_X);
  localparam logic [COORD_W-1:0] C_NODE_Y  = COORD_W'(NODE_Y);
  localparam logic [TTL_W-1:0]   C_TTL     = TTL_W'(TTL_INIT);

  state_t              r_state;
  state_t              w_next;
  logic [SEQ_W-1:0]    r_seq;
  logic [COORD_W-1:0]  r_dst_x;
  logic [COORD_W-1:0]  r_dst_y;
  logic [7:0]          r_len;
  logic [7:0]          r_rem;
  logic                r_err;

  logic                w_load;
  logic [FLIT_W-1:0]   w_load_data;
  logic                w_load_last;
  logic                w_load_ok;
  logic                w_last;
  logic                w_accept;
  logic                w_req_ok;
  logic                w_pl_fire;
  logic                w_xfer_last;

  assign req_ready = (r_state == IDLE) && rstn;
  assign w_accept  = req_valid && req_ready;

  assign w_req_ok = (req_len != 8'd0) && (req_len <= C_MAX_LEN) &&
                    ({1'b0, req_dst_x} < C_X) && ({1'b0, req_dst_y} < C_Y) &&
                    !((req_dst_x == C_NODE_X) && (req_dst_y == C_NODE_Y));

  assign w_pl_fire   = pl_valid && pl_ready;
  assign w_xfer_last = o_valid && i_ready && w_last;

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_data = '0;
    w_load_last = 1'b0;
    pl_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && w_req_ok) w_next = HDR;
      end
      HDR: begin
        w_load_data = pack_hdr(r_dst_x, r_dst_y, C_TTL);
        if (w_load_ok) begin
          w_load = 1'b1;
          w_next = ID;
        end
      end
      ID: begin
        w_load_data = pack_hdr(C_NODE_X, C_NODE_Y, r_seq);
        if (w_load_ok) begin
          w_load = 1'b1;
          w_next = LEN;
        end
      end
      LEN: begin
        w_load_data = r_len;
        if (w_load_ok) begin
          w_load = 1'b1;
          w_next = PAY;
        end
      end
      PAY: begin
        // Back-pressure reaches the payload source combinationally
        pl_ready    = w_load_ok;
        w_load_data = pl_data;
        w_load_last = (r_rem == 8'd1);
        if (pl_valid && w_load_ok) begin
          w_load = 1'b1;
          if (r_rem == 8'd1) w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_xfer_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_seq   <= '0;
      r_dst_x <= '0;
      r_dst_y <= '0;
      r_len   <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_accept && !w_req_ok;
      if (w_accept && w_req_ok) begin
        r_dst_x <= req_dst_x;
        r_dst_y <= req_dst_y;
        r_len   <= req_len;
      end
      if (r_state == LEN && w_load_ok) r_rem <= r_len;
      else if (w_pl_fire)              r_rem <= r_rem - 8'd1;
      if (r_state == DRAIN && w_xfer_last) r_seq <= r_seq + 1'b1;
    end
  end

  noc_flit_reg_slice #(
    .W (FLIT_W)
  ) u_slice (
    .clk       (clk),
    .rstn      (rstn),
    .load      (w_load),
    .load_data (w_load_data),
    .load_last (w_load_last),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_last    (w_last),
    .load_ok   (w_load_ok)
  );

  assign busy     = (r_state != IDLE);
  assign pkt_sent = (r_state == DRAIN) && w_xfer_last;
  assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_noc_packet_injector.sv
// ============================================================================
// Module   : tb_noc_packet_injector
// Brief    : Scoreboard bench for noc_packet_injector (X=3, Y=4, node (0,0)).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_noc_packet_injector;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_dst_x = '0;
  logic [1:0] req_dst_y = '0;
  logic [7:0] req_len = '0;
  logic       pl_valid = 1'b0;
  logic       pl_ready;
  logic [7:0] pl_data = '0;
  logic       o_valid;
  logic [7:0] o_data;
  logic       i_ready = 1'b1;
  logic       busy;
  logic       pkt_sent;
  logic       err;

  noc_packet_injector #(
    .X(3), .Y(4), .NODE_X(0), .NODE_Y(0), .TTL_INIT(6), .MAX_LEN(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_len(req_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .busy(busy), .pkt_sent(pkt_sent), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_seq = 4'd0;
  logic [7:0] pay[16];
  int         ir_mode = 0;
  bit         gap_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  // i_ready driver: always 1, or the repeating 1,0,0,1 pattern
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      if (ir_mode == 1) i_ready = ((cnt % 4) == 0) || ((cnt % 4) == 3);
      else              i_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks link stability
  initial begin
    exp_t       e;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    bit         prev_gap = 1'b0;
    bit         seen_busy = 1'b0;
    int         low_run = 0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (prev_stall) begin
          chk("stall_valid", {31'b0, o_valid}, 32'd1);
          chk("stall_data", {24'b0, o_data}, {24'b0, prev_data});
        end
        if (!i_ready && o_valid) chk("pl_ready_bp", {31'b0, pl_ready}, 32'd0);
        if (o_valid && i_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_flit: got %0h expected none at %0t", o_data, $time);
          end else begin
            e = sb.pop_front();
            chk("flit", {24'b0, o_data}, {24'b0, e.data});
            chk("pkt_sent", {31'b0, pkt_sent}, {31'b0, e.last});
          end
        end else begin
          chk("pkt_sent_idle", {31'b0, pkt_sent}, 32'd0);
        end
        prev_stall = o_valid && !i_ready;
        prev_data  = o_data;
      end else begin
        prev_stall = 1'b0;
      end
      if (gap_chk && !prev_gap) begin
        seen_busy = 1'b0;
        low_run   = 0;
      end
      if (gap_chk) begin
        if (busy) begin
          if (seen_busy && low_run > 0) chk("busy_gap", low_run, 32'd1);
          seen_busy = 1'b1;
          low_run   = 0;
        end else begin
          low_run++;
        end
      end
      prev_gap = gap_chk;
    end
  end

  task automatic do_req(input logic [1:0] dx, input logic [1:0] dy,
                        input logic [7:0] len, input bit good);
    int n = 0;
    req_valid = 1'b1;
    req_dst_x = dx;
    req_dst_y = dy;
    req_len   = len;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL req_timeout: got no req_ready expected accept at %0t", $time);
        req_valid = 1'b0;
        return;
      end
    end
    if (good) begin
      push({dx, dy, 4'd6}, 1'b0);
      push({4'd0, exp_seq}, 1'b0);
      push(len, 1'b0);
      for (int i = 0; i < int'(len); i++) push(pay[i], (i == int'(len) - 1));
      exp_seq = exp_seq + 4'd1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!good) begin
      chk("err_pulse", {31'b0, err}, 32'd1);
      chk("rej_busy", {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1;
      chk("err_clear", {31'b0, err}, 32'd0);
    end
  endtask

  task automatic send_pay(input int len, input int starve_idx);
    int n;
    for (int i = 0; i < len; i++) begin
      if (i == starve_idx) begin
        pl_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
      end
      pl_valid = 1'b1;
      pl_data  = pay[i];
      n = 0;
      forever begin
        @(negedge clk);
        if (pl_ready) break;
        n++;
        if (n > 200) begin
          checks++;
          errors++;
          $display("FAIL pl_timeout: got no pl_ready expected accept at %0t", $time);
          pl_valid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    pl_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_done", sb.size(), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_o_data", {24'b0, o_data}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_pl_ready", {31'b0, pl_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic packet: hand-computed flits 96 00 02 AA BB
    push(8'h96, 1'b0);
    push(8'h00, 1'b0);
    push(8'h02, 1'b0);
    push(8'hAA, 1'b0);
    push(8'hBB, 1'b1);
    pay[0] = 8'hAA;
    pay[1] = 8'hBB;
    req_valid = 1'b1;
    req_dst_x = 2'd2;
    req_dst_y = 2'd1;
    req_len   = 8'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_seq = 4'd1;
    send_pay(2, -1);
    wait_drain();

    // Second packet must carry seq 1 in F1
    do_req(2'd2, 2'd1, 8'd2, 1'b1);
    send_pay(2, -1);
    wait_drain();

    // Back-pressure
    ir_mode = 1;
    pay[0] = 8'h11;
    pay[1] = 8'h22;
    pay[2] = 8'h33;
    do_req(2'd1, 2'd3, 8'd3, 1'b1);
    send_pay(3, -1);
    wait_drain();
    ir_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Rejects
    chk("idle_pl_ready", {31'b0, pl_ready}, 32'd0);
    do_req(2'd1, 2'd1, 8'd0, 1'b0);
    do_req(2'd1, 2'd1, 8'd17, 1'b0);
    do_req(2'd0, 2'd0, 8'd2, 1'b0);
    do_req(2'd3, 2'd1, 8'd2, 1'b0);
    chk("rej_o_valid", {31'b0, o_valid}, 32'd0);
    pay[0] = 8'h5A;
    do_req(2'd2, 2'd3, 8'd1, 1'b1);
    send_pay(1, -1);
    wait_drain();

    // Reset to zero seq, then 17 back-to-back packets for the wrap
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_seq = 4'd0;
    gap_chk = 1'b1;
    for (int k = 0; k < 17; k++) begin
      pay[0] = 8'(k + 8'h40);
      do_req(2'd1, 2'd2, 8'd1, 1'b1);
      send_pay(1, -1);
    end
    wait_drain();
    gap_chk = 1'b0;

    // Reset mid-packet with three payload bytes still outstanding
    for (int i = 0; i < 5; i++) pay[i] = 8'(8'hC0 + i);
    do_req(2'd2, 2'd2, 8'd5, 1'b1);
    send_pay(2, -1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    chk("midrst_o_valid", {31'b0, o_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    rstn = 1'b1;
    exp_seq = 4'd0;
    pay[0] = 8'hD1;
    pay[1] = 8'hD2;
    do_req(2'd0, 2'd1, 8'd2, 1'b1);
    send_pay(2, -1);
    wait_drain();

    // Payload starvation for 5 cycles mid-payload
    for (int i = 0; i < 4; i++) pay[i] = 8'(8'hE0 + i);
    do_req(2'd1, 2'd0, 8'd4, 1'b1);
    send_pay(4, 2);
    wait_drain();

    repeat (5) @(posedge clk);
    #1;
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
